morse_rx_ctrl: RTL

Receive-side controller for the Morse decoder path. It measures the operator's keying speed on the raw `signal` line and publishes the dit length in clocks (`unit_len`) that configures the dit/dah classifier at run time. It also buffers the letters produced by the alphabet FSM in a small FIFO with a valid/ready handshake toward the consumer (UART/display). It sits beside the decoder, between the raw key input and the letter sink.

---
 rtl/morse_pkg.sv | 16 +
 rtl/morse_letter_fifo.sv | 63 ++++++
 rtl/morse_rx_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared Morse decoder constants and calibration state encoding.
// Used by the receive controller and the decoder top.
package morse_pkg;

  localparam int MORSE_CW           = 16;
  localparam int MORSE_DEFAULT_UNIT = 27;
  localparam int MORSE_MIN_MARK     = 2;

  typedef enum logic [1:0] {
    CAL_IDLE,
    CAL_WAIT_LOW,
    CAL_MEASURE,
    CAL_UPDATE
  } cal_state_e;

endpackage

// File: rtl/morse_letter_fifo.sv
// Letter FIFO with registered head, no fall-through, sticky overflow.
// DEPTH must be a power of two, at least 2.
module morse_letter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       ovf_clr,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_push;
  logic          do_pop;
  logic          drop;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
      // head tracks the next entry; holds its value when drained
      if (do_pop) begin
        if (count > ONE)  head <= mem[rd_ptr + 1'b1];
        else if (do_push) head <= din;
      end else if (do_push && empty) begin
        head <= din;
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/morse_rx_ctrl.sv
// Morse receive controller: keying-speed calibration plus letter FIFO.
// Optional MORSE_CAL_TIMEOUT_EN aborts a stalled calibration.
module morse_rx_ctrl
  import morse_pkg::*;
#(
  parameter int CW           = MORSE_CW,
  parameter int DEFAULT_UNIT = MORSE_DEFAULT_UNIT,
  parameter int CAL_MARKS    = 8,
  parameter int DEPTH        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          signal,
  input  logic          cal_start,
  output logic          cal_busy,
  output logic          cal_done,
  output logic          cal_err,
  output logic [CW-1:0] unit_len,
  input  logic [7:0]    letter_in,
  input  logic          letter_stb,
  output logic [7:0]    letter_out,
  output logic          letter_valid,
  input  logic          letter_ready,
  output logic          overflow
);

  localparam logic [CW-1:0] RUN_MAX  = '1;
  localparam logic [CW-1:0] MIN_MARK = CW'(MORSE_MIN_MARK);
  localparam logic [CW-1:0] UNIT_RST = CW'(DEFAULT_UNIT);
  localparam logic [7:0]    LAST_IDX = 8'(CAL_MARKS - 1);

  cal_state_e    state;
  cal_state_e    state_nxt;
  logic          sig_q;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] min_len;
  logic [CW-1:0] unit_q;
  logic [7:0]    mark_cnt;
  logic          cal_done_q;
  logic          fall;
  logic          start_ok;
  logic          valid_mark;
  logic          last_mark;
  logic          tmo_hit;
  logic          fifo_empty;

  assign fall       = sig_q && !signal;
  assign start_ok   = (state == CAL_IDLE) && cal_start;
  assign valid_mark = (state == CAL_MEASURE) && fall
                      && (run_cnt >= MIN_MARK);
  assign last_mark  = valid_mark && (mark_cnt == LAST_IDX);

  assign cal_busy = (state != CAL_IDLE);
  assign cal_done = cal_done_q;
  assign unit_len = unit_q;

`ifdef MORSE_CAL_TIMEOUT_EN
  logic [CW-1:0] quiet_cnt;
  logic          cal_err_q;

  assign tmo_hit = (state == CAL_MEASURE) && (quiet_cnt == RUN_MAX);
  assign cal_err = cal_err_q;

  // cycles since the last level change while measuring
  always_ff @(posedge clk) begin
    if (!rst_n || state != CAL_MEASURE || signal != sig_q)
      quiet_cnt <= '0;
    else if (!tmo_hit)
      quiet_cnt <= quiet_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cal_err_q <= 1'b0;
    else        cal_err_q <= tmo_hit && !last_mark;
  end
`else
  assign tmo_hit = 1'b0;
  assign cal_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      CAL_IDLE:
        if (cal_start)
          state_nxt = signal ? CAL_WAIT_LOW : CAL_MEASURE;
      CAL_WAIT_LOW:
        if (!signal) state_nxt = CAL_MEASURE;
      CAL_MEASURE:
        if (last_mark)    state_nxt = CAL_UPDATE;
        else if (tmo_hit) state_nxt = CAL_IDLE;
      CAL_UPDATE:
        state_nxt = CAL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CAL_IDLE;
      sig_q      <= 1'b0;
      run_cnt    <= '0;
      min_len    <= '1;
      mark_cnt   <= '0;
      unit_q     <= UNIT_RST;
      cal_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      sig_q      <= signal;
      cal_done_q <= (state == CAL_UPDATE);
      if (start_ok) begin
        min_len  <= '1;
        mark_cnt <= '0;
        run_cnt  <= '0;
      end else if (state == CAL_MEASURE) begin
        if (fall)
          run_cnt <= '0;
        else if (signal && run_cnt != RUN_MAX)
          run_cnt <= run_cnt + 1'b1;
        if (valid_mark) begin
          mark_cnt <= mark_cnt + 1'b1;
          if (run_cnt < min_len) min_len <= run_cnt;
        end
      end
      if (state == CAL_UPDATE) unit_q <= min_len;
    end
  end

  morse_letter_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (letter_stb),
    .pop     (letter_ready),
    .ovf_clr (start_ok),
    .din     (letter_in),
    .head    (letter_out),
    .empty   (fifo_empty),
    .overflow(overflow)
  );

  assign letter_valid = !fifo_empty;

endmodule
